// File: rtl/csr_trap_sequencer.sv
// -----------------------------------------------------------------------------
// csr_trap_sequencer
//
// Purpose:
//   Sequences machine-mode trap entry and MRET through the single CSR-file
//   write port. It also grants that port to the pipeline whenever the
//   sequencer is idle and no event is accepted in that cycle.
//
//   Trap entry uses four states: write mepc, write mcause, write mstatus,
//   then a one-cycle fetch redirect. MRET uses two states: write mstatus,
//   then a redirect to the captured mepc.
//
// State table:
//   state       | meaning
//   ------------+-----------------------------------------------------------
//   IDLE        | pipeline owns the CSR port; sample exc > irq > mret
//   SAVE_EPC    | write mepc (0x341) with the captured PC
//   SAVE_CAUSE  | write mcause (0x342) with the captured cause
//   SAVE_STATUS | write mstatus (0x300): MPIE<=MIE, MIE<=0, MPP<=11
//   TRAP_REDIR  | redirect fetch to the mtvec-derived target
//   MRET_STATUS | write mstatus (0x300): MIE<=MPIE, MPIE<=1
//   MRET_REDIR  | redirect fetch to the captured mepc
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   exc_valid/exc_cause/exc_pc    exception request, cause code, faulting PC
//   irq_pc                        PC saved on interrupt entry
//   mret_valid                    MRET retire request
//   mstatus_q..mepc_q             current CSR-file contents
//   pipe_csr_*                    pipeline CSR access request
//   pipe_csr_ready                pipeline access granted this cycle
//   csr_we/csr_addr/csr_wdata     CSR-file write port
//   redirect_valid/redirect_pc    one-cycle fetch redirect
//   busy                          high whenever the state is not IDLE
// -----------------------------------------------------------------------------
module csr_trap_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        exc_valid,
    input  logic [31:0] exc_cause,
    input  logic [31:0] exc_pc,
    input  logic [31:0] irq_pc,
    input  logic        mret_valid,
    input  logic [31:0] mstatus_q,
    input  logic [31:0] mie_q,
    input  logic [31:0] mip_q,
    input  logic [31:0] mtvec_q,
    input  logic [31:0] mepc_q,
    input  logic        pipe_csr_req,
    input  logic        pipe_csr_we,
    input  logic [11:0] pipe_csr_addr,
    input  logic [31:0] pipe_csr_wdata,
    output logic        pipe_csr_ready,
    output logic        csr_we,
    output logic [11:0] csr_addr,
    output logic [31:0] csr_wdata,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        busy
);

    localparam logic [2:0] IDLE        = 3'd0;
    localparam logic [2:0] SAVE_EPC    = 3'd1;
    localparam logic [2:0] SAVE_CAUSE  = 3'd2;
    localparam logic [2:0] SAVE_STATUS = 3'd3;
    localparam logic [2:0] TRAP_REDIR  = 3'd4;
    localparam logic [2:0] MRET_STATUS = 3'd5;
    localparam logic [2:0] MRET_REDIR  = 3'd6;

    localparam logic [11:0] ADDR_MSTATUS = 12'h300;
    localparam logic [11:0] ADDR_MEPC    = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE  = 12'h342;

    logic [2:0]  state;
    logic [31:0] epc_r;
    logic [31:0] cause_r;
    logic [31:0] mstatus_r;
    logic [31:0] mtvec_r;
    logic [31:0] mepc_r;
    logic        irq_r;

    logic [31:0] irq_pend;
    logic        irq_take;
    logic [3:0]  irq_code;
    logic        event_seen;
    logic [31:0] trap_status;
    logic [31:0] mret_status;
    logic [31:0] trap_base;
    logic [31:0] trap_target;

    // Only MEI/MSI/MTI participate; the remaining pending bits are ignored.
    logic unused_pend;
    assign unused_pend = ^{irq_pend[31:12], irq_pend[10:8], irq_pend[6:4], irq_pend[2:0]};

    always_comb begin
        irq_pend = mip_q & mie_q;
        irq_take = mstatus_q[3] & (irq_pend[11] | irq_pend[3] | irq_pend[7]);
        if (irq_pend[11])
            irq_code = 4'd11;
        else if (irq_pend[3])
            irq_code = 4'd3;
        else
            irq_code = 4'd7;
        event_seen = exc_valid | irq_take | mret_valid;
    end

    always_comb begin
        trap_status       = mstatus_r;
        trap_status[7]    = mstatus_r[3];
        trap_status[3]    = 1'b0;
        trap_status[12:11] = 2'b11;

        mret_status    = mstatus_r;
        mret_status[3] = mstatus_r[7];
        mret_status[7] = 1'b1;

        // Vectored mode only offsets interrupts; exceptions land on the base.
        trap_base = {mtvec_r[31:2], 2'b00};
        if ((mtvec_r[1:0] == 2'b01) && irq_r)
            trap_target = trap_base + {cause_r[29:0], 2'b00};
        else
            trap_target = trap_base;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            epc_r     <= '0;
            cause_r   <= '0;
            mstatus_r <= '0;
            mtvec_r   <= '0;
            mepc_r    <= '0;
            irq_r     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (event_seen) begin
                        mstatus_r <= mstatus_q;
                        mtvec_r   <= mtvec_q;
                        mepc_r    <= mepc_q;
                    end
                    if (exc_valid) begin
                        epc_r   <= exc_pc;
                        cause_r <= exc_cause;
                        irq_r   <= 1'b0;
                        state   <= SAVE_EPC;
                    end else if (irq_take) begin
                        epc_r   <= irq_pc;
                        cause_r <= {1'b1, 27'b0, irq_code};
                        irq_r   <= 1'b1;
                        state   <= SAVE_EPC;
                    end else if (mret_valid) begin
                        state   <= MRET_STATUS;
                    end
                end
                SAVE_EPC:    state <= SAVE_CAUSE;
                SAVE_CAUSE:  state <= SAVE_STATUS;
                SAVE_STATUS: state <= TRAP_REDIR;
                TRAP_REDIR:  state <= IDLE;
                MRET_STATUS: state <= MRET_REDIR;
                MRET_REDIR:  state <= IDLE;
                default:     state <= IDLE;
            endcase
        end
    end

    always_comb begin
        pipe_csr_ready = 1'b0;
        csr_we         = 1'b0;
        csr_addr       = pipe_csr_addr;
        csr_wdata      = pipe_csr_wdata;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        busy           = (state != IDLE);
        case (state)
            IDLE: begin
                // An accepted event takes the port; the pipeline write is dropped.
                if (!event_seen) begin
                    pipe_csr_ready = 1'b1;
                    csr_we         = pipe_csr_req & pipe_csr_we;
                end
            end
            SAVE_EPC: begin
                csr_we    = 1'b1;
                csr_addr  = ADDR_MEPC;
                csr_wdata = epc_r;
            end
            SAVE_CAUSE: begin
                csr_we    = 1'b1;
                csr_addr  = ADDR_MCAUSE;
                csr_wdata = cause_r;
            end
            SAVE_STATUS: begin
                csr_we    = 1'b1;
                csr_addr  = ADDR_MSTATUS;
                csr_wdata = trap_status;
            end
            TRAP_REDIR: begin
                redirect_valid = 1'b1;
                redirect_pc    = trap_target;
            end
            MRET_STATUS: begin
                csr_we    = 1'b1;
                csr_addr  = ADDR_MSTATUS;
                csr_wdata = mret_status;
            end
            MRET_REDIR: begin
                redirect_valid = 1'b1;
                redirect_pc    = mepc_r;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_csr_trap_sequencer.sv
// -----------------------------------------------------------------------------
// tb_csr_trap_sequencer
//
// Purpose:
//   Directed testbench for csr_trap_sequencer. The expected values are worked
//   out by hand from the trap and MRET rules.
//
//   Inputs are driven on the falling edge. Outputs are sampled 1 ns after that
//   edge, which keeps sampling well away from the rising (active) edge.
// -----------------------------------------------------------------------------
module tb_csr_trap_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        exc_valid;
    logic [31:0] exc_cause;
    logic [31:0] exc_pc;
    logic [31:0] irq_pc;
    logic        mret_valid;
    logic [31:0] mstatus_q;
    logic [31:0] mie_q;
    logic [31:0] mip_q;
    logic [31:0] mtvec_q;
    logic [31:0] mepc_q;
    logic        pipe_csr_req;
    logic        pipe_csr_we;
    logic [11:0] pipe_csr_addr;
    logic [31:0] pipe_csr_wdata;
    logic        pipe_csr_ready;
    logic        csr_we;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    csr_trap_sequencer dut (
        .clk            (clk),
        .rst            (rst),
        .exc_valid      (exc_valid),
        .exc_cause      (exc_cause),
        .exc_pc         (exc_pc),
        .irq_pc         (irq_pc),
        .mret_valid     (mret_valid),
        .mstatus_q      (mstatus_q),
        .mie_q          (mie_q),
        .mip_q          (mip_q),
        .mtvec_q        (mtvec_q),
        .mepc_q         (mepc_q),
        .pipe_csr_req   (pipe_csr_req),
        .pipe_csr_we    (pipe_csr_we),
        .pipe_csr_addr  (pipe_csr_addr),
        .pipe_csr_wdata (pipe_csr_wdata),
        .pipe_csr_ready (pipe_csr_ready),
        .csr_we         (csr_we),
        .csr_addr       (csr_addr),
        .csr_wdata      (csr_wdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .busy           (busy)
    );

    task automatic clear_inputs();
        exc_valid      = 1'b0;
        exc_cause      = '0;
        exc_pc         = '0;
        irq_pc         = '0;
        mret_valid     = 1'b0;
        mstatus_q      = '0;
        mie_q          = '0;
        mip_q          = '0;
        mtvec_q        = '0;
        mepc_q         = '0;
        pipe_csr_req   = 1'b0;
        pipe_csr_we    = 1'b0;
        pipe_csr_addr  = '0;
        pipe_csr_wdata = '0;
    endtask

    // Per-cycle expectation tables. Cycle 0 is the acceptance cycle; cycle k is N+k.
    // The address and data are compared only in cycles where a write is expected;
    // the redirect PC only in cycles where a redirect is expected.
    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        repeat (2) @(negedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        checks++; if (redirect_valid !== 1'b0) begin failures++; $display("FAIL reset_redirect_valid got=%0b exp=0", redirect_valid); end
        checks++; if (redirect_pc !== 32'h0) begin failures++; $display("FAIL reset_redirect_pc got=%h exp=0", redirect_pc); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (pipe_csr_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%0b exp=1", pipe_csr_ready); end
        checks++; if (csr_we !== 1'b0) begin failures++; $display("FAIL reset_csr_we got=%0b exp=0", csr_we); end
    endtask

    task automatic test_exception();
        logic        ew [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [11:0] ea [5] = '{12'h000, 12'h341, 12'h342, 12'h300, 12'h000};
        logic [31:0] ed [5] = '{32'h0, 32'h100, 32'h2, 32'h1880, 32'h0};
        logic        er [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic        eb [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        @(negedge clk);
        exc_valid = 1'b1; exc_cause = 32'd2; exc_pc = 32'h100;
        mstatus_q = 32'h8; mtvec_q = 32'h1000;
        for (int c = 0; c < 5; c++) begin
            if (c > 0) begin
                @(negedge clk);
                if (c == 1) begin
                    // Live CSR values change after acceptance; the sequence must use the captured ones.
                    exc_valid = 1'b0; mtvec_q = 32'hDEAD_0000; mstatus_q = 32'h0;
                end
            end
            #1;
            checks++; if (csr_we !== ew[c]) begin failures++; $display("FAIL exc_we c%0d got=%0b exp=%0b", c, csr_we, ew[c]); end
            checks++; if (busy !== eb[c]) begin failures++; $display("FAIL exc_busy c%0d got=%0b exp=%0b", c, busy, eb[c]); end
            checks++; if (redirect_valid !== er[c]) begin failures++; $display("FAIL exc_rv c%0d got=%0b exp=%0b", c, redirect_valid, er[c]); end
            checks++; if (pipe_csr_ready !== 1'b0) begin failures++; $display("FAIL exc_ready c%0d got=%0b exp=0", c, pipe_csr_ready); end
            if (ew[c]) begin
                checks++; if (csr_addr !== ea[c]) begin failures++; $display("FAIL exc_addr c%0d got=%h exp=%h", c, csr_addr, ea[c]); end
                checks++; if (csr_wdata !== ed[c]) begin failures++; $display("FAIL exc_data c%0d got=%h exp=%h", c, csr_wdata, ed[c]); end
            end
            if (er[c]) begin
                checks++; if (redirect_pc !== 32'h1000) begin failures++; $display("FAIL exc_rpc got=%h exp=00001000", redirect_pc); end
            end
        end
        @(negedge clk); #1;
        checks++; if (busy !== 1'b0 || redirect_valid !== 1'b0) begin failures++; $display("FAIL exc_end busy=%0b rv=%0b exp=0/0", busy, redirect_valid); end
        clear_inputs();
    endtask

    // Each run is one interrupt: mie=mip=pend, interrupts globally enabled.
    task automatic run_irq(input logic [31:0] pend, input logic [31:0] tvec,
                           input logic [31:0] exp_cause, input logic [31:0] exp_pc, input string tag);
        logic [11:0] ea [4] = '{12'h000, 12'h341, 12'h342, 12'h300};
        logic [31:0] ed [4];
        ed = '{32'h0, 32'h500, exp_cause, 32'h1880};
        @(negedge clk);
        mstatus_q = 32'h8; mie_q = pend; mip_q = pend; mtvec_q = tvec; irq_pc = 32'h500;
        #1;
        checks++; if (pipe_csr_ready !== 1'b0) begin failures++; $display("FAIL %s_accept_ready got=%0b exp=0", tag, pipe_csr_ready); end
        for (int c = 1; c < 4; c++) begin
            @(negedge clk);
            if (c == 1) begin mie_q = '0; mip_q = '0; end
            #1;
            checks++; if (csr_we !== 1'b1 || csr_addr !== ea[c] || csr_wdata !== ed[c]) begin
                failures++; $display("FAIL %s_write c%0d got we=%0b %h=%h exp we=1 %h=%h", tag, c, csr_we, csr_addr, csr_wdata, ea[c], ed[c]);
            end
        end
        @(negedge clk); #1;
        checks++; if (redirect_valid !== 1'b1 || redirect_pc !== exp_pc) begin
            failures++; $display("FAIL %s_redirect got rv=%0b pc=%h exp rv=1 pc=%h", tag, redirect_valid, redirect_pc, exp_pc);
        end
        @(negedge clk); #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL %s_end_busy got=%0b exp=0", tag, busy); end
        clear_inputs();
    endtask

    task automatic test_irq();
        run_irq(32'h880, 32'h2001, 32'h8000_000B, 32'h202C, "irq_vec_mei");
        run_irq(32'h088, 32'h2000, 32'h8000_0003, 32'h2000, "irq_dir_msi");
        run_irq(32'h080, 32'h3001, 32'h8000_0007, 32'h301C, "irq_vec_mti");
    endtask

    task automatic test_masked_irq();
        @(negedge clk);
        mstatus_q = 32'h0; mip_q = 32'h80; mie_q = 32'h80;
        pipe_csr_req = 1'b1; pipe_csr_we = 1'b1; pipe_csr_addr = 12'h305; pipe_csr_wdata = 32'h1234;
        for (int c = 0; c < 3; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mask_busy c%0d got=%0b exp=0", c, busy); end
            checks++; if (pipe_csr_ready !== 1'b1 || csr_we !== 1'b1 || csr_addr !== 12'h305 || csr_wdata !== 32'h1234) begin
                failures++; $display("FAIL mask_pass c%0d got rdy=%0b we=%0b %h=%h exp rdy=1 we=1 305=00001234", c, pipe_csr_ready, csr_we, csr_addr, csr_wdata);
            end
        end
        // A read request (we=0) must not produce a write.
        pipe_csr_we = 1'b0; #1;
        checks++; if (csr_we !== 1'b0) begin failures++; $display("FAIL mask_read_we got=%0b exp=0", csr_we); end
        clear_inputs();
    endtask

    task automatic test_mret();
        @(negedge clk);
        mret_valid = 1'b1; mstatus_q = 32'h1880; mepc_q = 32'h344;
        #1;
        checks++; if (pipe_csr_ready !== 1'b0 || csr_we !== 1'b0) begin failures++; $display("FAIL mret_accept got rdy=%0b we=%0b exp 0/0", pipe_csr_ready, csr_we); end
        @(negedge clk);
        mret_valid = 1'b0; mepc_q = 32'hBAD0; mstatus_q = 32'h0;
        #1;
        checks++; if (csr_we !== 1'b1 || csr_addr !== 12'h300 || csr_wdata !== 32'h1888) begin
            failures++; $display("FAIL mret_status got we=%0b %h=%h exp we=1 300=00001888", csr_we, csr_addr, csr_wdata);
        end
        checks++; if (redirect_valid !== 1'b0) begin failures++; $display("FAIL mret_early_rv got=%0b exp=0", redirect_valid); end
        @(negedge clk); #1;
        checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h344 || csr_we !== 1'b0) begin
            failures++; $display("FAIL mret_redirect got rv=%0b pc=%h we=%0b exp rv=1 pc=00000344 we=0", redirect_valid, redirect_pc, csr_we);
        end
        @(negedge clk); #1;
        checks++; if (busy !== 1'b0 || redirect_valid !== 1'b0) begin failures++; $display("FAIL mret_end busy=%0b rv=%0b exp 0/0", busy, redirect_valid); end
        clear_inputs();
    endtask

    task automatic test_contention();
        logic        ew [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [11:0] ea [6] = '{12'h000, 12'h341, 12'h342, 12'h300, 12'h000, 12'h304};
        logic [31:0] ed [6] = '{32'h0, 32'h200, 32'h5, 32'h1880, 32'h0, 32'hAAA};
        logic        ey [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic        er [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        @(negedge clk);
        exc_valid = 1'b1; exc_cause = 32'd5; exc_pc = 32'h200; mstatus_q = 32'h8; mtvec_q = 32'h1000;
        pipe_csr_req = 1'b1; pipe_csr_we = 1'b1; pipe_csr_addr = 12'h304; pipe_csr_wdata = 32'hAAA;
        for (int c = 0; c < 6; c++) begin
            if (c > 0) begin
                @(negedge clk);
                if (c == 1) exc_valid = 1'b0;
            end
            #1;
            checks++; if (pipe_csr_ready !== ey[c]) begin failures++; $display("FAIL cont_ready c%0d got=%0b exp=%0b", c, pipe_csr_ready, ey[c]); end
            checks++; if (csr_we !== ew[c] || redirect_valid !== er[c]) begin
                failures++; $display("FAIL cont_ctl c%0d got we=%0b rv=%0b exp we=%0b rv=%0b", c, csr_we, redirect_valid, ew[c], er[c]);
            end
            if (ew[c]) begin
                checks++; if (csr_addr !== ea[c] || csr_wdata !== ed[c]) begin
                    failures++; $display("FAIL cont_write c%0d got %h=%h exp %h=%h", c, csr_addr, csr_wdata, ea[c], ed[c]);
                end
            end
        end
        clear_inputs();
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        exc_valid = 1'b1; exc_cause = 32'd3; exc_pc = 32'h700; mstatus_q = 32'h8; mtvec_q = 32'h1000;
        @(negedge clk);
        exc_valid = 1'b0;
        @(negedge clk); #1;
        checks++; if (csr_we !== 1'b1 || csr_addr !== 12'h342) begin failures++; $display("FAIL rstmid_cause got we=%0b addr=%h exp we=1 addr=342", csr_we, csr_addr); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%0b exp=0", busy); end
        for (int c = 0; c < 4; c++) begin
            if (c > 0) begin @(negedge clk); #1; end
            checks++; if (csr_we !== 1'b0 || redirect_valid !== 1'b0) begin
                failures++; $display("FAIL rstmid_quiet c%0d got we=%0b rv=%0b exp 0/0", c, csr_we, redirect_valid);
            end
        end
        clear_inputs();
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        exc_valid = 1'b1; mret_valid = 1'b1; exc_cause = 32'd7; exc_pc = 32'h40;
        mstatus_q = 32'h8; mepc_q = 32'h999; mtvec_q = 32'h3000;
        @(negedge clk);
        // mret stays asserted while busy; it must be ignored.
        exc_valid = 1'b0;
        #1;
        checks++; if (csr_we !== 1'b1 || csr_addr !== 12'h341 || csr_wdata !== 32'h40) begin
            failures++; $display("FAIL b2b_epc got we=%0b %h=%h exp we=1 341=00000040", csr_we, csr_addr, csr_wdata);
        end
        repeat (3) @(negedge clk);
        #1;
        checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h3000) begin
            failures++; $display("FAIL b2b_redirect got rv=%0b pc=%h exp rv=1 pc=00003000", redirect_valid, redirect_pc);
        end
        @(negedge clk);
        mret_valid = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || csr_we !== 1'b0) begin failures++; $display("FAIL b2b_idle busy=%0b we=%0b exp 0/0", busy, csr_we); end
        @(negedge clk); #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL b2b_mret_ignored busy=%0b exp=0", busy); end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_exception();
        test_irq();
        test_masked_irq();
        test_mret();
        test_contention();
        test_reset_mid();
        test_back_to_back();
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
